alu_serial32: RTL

ALU_SERIAL32 -- requirements
Module: alu_serial32

---
 rtl/alu_serial32.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_serial32.sv
// Bit-serial ALU: one bit-slice with a registered carry, LSB first, one bit per RUN cycle.
// Valid/ready on both sides; operands and opcode are captured when the request is accepted.
//
// state | meaning
// IDLE  | waiting for a request (in_ready high once reset release has synchronised)
// RUN   | processing bit cnt_q of the captured operands
// DONE  | result held on R/Cout until the consumer takes it
module alu_serial32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             Cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       rst_sync_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic [2:0]       f_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;

    logic hold, accept, last, inv, is_arith, is_slt;
    logic a_bit, b_raw, b_eff, sum_bit, carry_nxt, res_bit, slt_bit;

    // Requests are refused until the release of rst_n has passed two flops.
    assign hold     = rst_n && !rst_sync_q[1];
    assign in_ready = (state_q == IDLE) && !hold;
    assign accept   = in_valid && in_ready;
    assign last     = (state_q == RUN) && (cnt_q == LAST);

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign R         = r_q;
    assign Cout      = cout_q;

    assign inv      = (f_q == OP_SUB) || (f_q == OP_SLT);
    assign is_arith = (f_q == OP_ADD) || (f_q == OP_SUB);
    assign is_slt   = (f_q == OP_SLT);

    assign a_bit     = a_q[0];
    assign b_raw     = b_q[0];
    assign b_eff     = b_raw ^ inv;
    assign sum_bit   = a_bit ^ b_eff ^ carry_q;
    assign carry_nxt = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);
    // On the MSB slice, carry_q is the carry in and carry_nxt the carry out.
    assign slt_bit   = sum_bit ^ (carry_q ^ carry_nxt);

    always_comb begin
        res_bit = 1'b0;
        case (f_q)
            OP_AND:                 res_bit = a_bit & b_raw;
            OP_OR:                  res_bit = a_bit | b_raw;
            OP_XOR:                 res_bit = a_bit ^ b_raw;
            OP_NOR:                 res_bit = ~(a_bit | b_raw);
            OP_ADD, OP_SUB, OP_SLT: res_bit = sum_bit;
            default:                res_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= 3'b000;
            r_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= A;
                        b_q     <= B;
                        f_q     <= F;
                        carry_q <= (F == OP_SUB) || (F == OP_SLT);
                        cout_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_nxt;
                    if (last) begin
                        cnt_q  <= '0;
                        cout_q <= is_arith & carry_nxt;
                        if (is_slt) begin
                            r_q <= {{(WIDTH-1){1'b0}}, slt_bit};
                        end else begin
                            r_q <= {res_bit, r_q[WIDTH-1:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        r_q   <= {res_bit, r_q[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
